// File: rtl/axil_gpio_pkg.sv
// axil_gpio_pkg: shared constants, register selector type and helpers for the
// AXI4-Lite GPIO register block (axil_gpio_regs).
package axil_gpio_pkg;

  localparam logic [31:0] ID_VALUE_DEFAULT = 32'hBE4C_0001;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Byte offsets of the registers (address bits [1:0] are ignored).
  localparam logic [31:0] OFF_ID       = 32'h00;
  localparam logic [31:0] OFF_SCRATCH  = 32'h04;
  localparam logic [31:0] OFF_GPIO_OUT = 32'h08;
  localparam logic [31:0] OFF_GPIO_TRI = 32'h0C;
  localparam logic [31:0] OFF_GPIO_IN  = 32'h10;
  localparam logic [31:0] OFF_CYCLES   = 32'h14;
  localparam logic [31:0] OFF_WR_COUNT = 32'h18;
  localparam logic [31:0] OFF_EDGE     = 32'h1C;

  typedef enum logic [2:0] {
    SEL_ID,
    SEL_SCRATCH,
    SEL_GPIO_OUT,
    SEL_GPIO_TRI,
    SEL_GPIO_IN,
    SEL_CYCLES,
    SEL_WR_COUNT,
    SEL_EDGE
  } reg_sel_e;

  typedef struct packed {
    logic     hit;
    reg_sel_e sel;
  } reg_dec_t;

  // Map a word-aligned byte offset onto a register; EDGE only exists when enabled.
  function automatic reg_dec_t decode_offset(input logic [31:0] off, input logic edge_en);
    reg_dec_t d;
    d.hit = 1'b1;
    d.sel = SEL_ID;
    case (off)
      OFF_ID:       d.sel = SEL_ID;
      OFF_SCRATCH:  d.sel = SEL_SCRATCH;
      OFF_GPIO_OUT: d.sel = SEL_GPIO_OUT;
      OFF_GPIO_TRI: d.sel = SEL_GPIO_TRI;
      OFF_GPIO_IN:  d.sel = SEL_GPIO_IN;
      OFF_CYCLES:   d.sel = SEL_CYCLES;
      OFF_WR_COUNT: d.sel = SEL_WR_COUNT;
      OFF_EDGE: begin
        d.sel = SEL_EDGE;
        d.hit = edge_en;
      end
      default:      d.hit = 1'b0;
    endcase
    return d;
  endfunction

  // Byte-lane merge of new data into an old value under a strobe mask.
  function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/axil_gpio_regs_gpio_sync.sv
// gpio_sync: 2-FF synchroniser for asynchronous button inputs plus a
// rising-edge pulse on the synchronised value.
module gpio_sync #(
  parameter int GPIO_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [GPIO_W-1:0] raw,
  output logic [GPIO_W-1:0] synced,
  output logic [GPIO_W-1:0] rise
);

  logic [GPIO_W-1:0] meta_q;
  logic [GPIO_W-1:0] sync_q;
  logic [GPIO_W-1:0] prev_q;

  // Two flops for metastability settling, a third to remember the last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= raw;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign synced = sync_q;
  assign rise   = sync_q & ~prev_q;

endmodule

// File: rtl/axil_gpio_regs.sv
// axil_gpio_regs: AXI4-Lite responder with ID, scratch, GPIO and benchmark
// counter registers. Optional EDGE register (0x1C) is built when the macro
// AXIL_GPIO_EDGE_EN is defined; otherwise 0x1C is unmapped.
//
// Handshakes: a transfer happens on a rising clock edge where valid && ready.
// A responder valid, once raised, stays high with stable payload until ready.
// AW and W each land in a one-entry hold (ready low while full); the write
// commits when both are available and the B slot is free, and may bypass the
// holds so that a simultaneous AW+W produces bvalid one cycle later.
module axil_gpio_regs
  import axil_gpio_pkg::*;
#(
  parameter int          ADDR_W   = 9,
  parameter int          GPIO_W   = 2,
  parameter logic [31:0] ID_VALUE = ID_VALUE_DEFAULT
) (
  input  logic              m_axi_lite_aclk,
  input  logic              m_axi_lite_aresetn,
  input  logic              m_axi_lite_awvalid,
  output logic              m_axi_lite_awready,
  input  logic [ADDR_W-1:0] m_axi_lite_awaddr,
  input  logic [2:0]        m_axi_lite_awprot,
  input  logic              m_axi_lite_wvalid,
  output logic              m_axi_lite_wready,
  input  logic [31:0]       m_axi_lite_wdata,
  input  logic [3:0]        m_axi_lite_wstrb,
  output logic              m_axi_lite_bvalid,
  input  logic              m_axi_lite_bready,
  output logic [1:0]        m_axi_lite_bresp,
  input  logic              m_axi_lite_arvalid,
  output logic              m_axi_lite_arready,
  input  logic [ADDR_W-1:0] m_axi_lite_araddr,
  input  logic [2:0]        m_axi_lite_arprot,
  output logic              m_axi_lite_rvalid,
  input  logic              m_axi_lite_rready,
  output logic [31:0]       m_axi_lite_rdata,
  output logic [1:0]        m_axi_lite_rresp,
  input  logic [GPIO_W-1:0] gpio_io_i,
  output logic [GPIO_W-1:0] gpio_io_o,
  output logic [GPIO_W-1:0] gpio_io_t
);

`ifdef AXIL_GPIO_EDGE_EN
  localparam logic EDGE_EN = 1'b1;
`else
  localparam logic EDGE_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  assign clk   = m_axi_lite_aclk;
  assign rst_n = m_axi_lite_aresetn;

  // Write holds
  logic              aw_held;
  logic [ADDR_W-1:2] aw_addr_q;
  logic              w_held;
  logic [31:0]       w_data_q;
  logic [3:0]        w_strb_q;

  // Registers
  logic [31:0]       scratch_q;
  logic [GPIO_W-1:0] gpio_o_q;
  logic [GPIO_W-1:0] gpio_t_q;
  logic [31:0]       cycles_q;
  logic [31:0]       wr_count_q;
  logic [GPIO_W-1:0] edge_q;

  logic [GPIO_W-1:0] gpio_in_sync;
  logic [GPIO_W-1:0] gpio_rise;

  // Write path signals
  logic              aw_fire, w_fire, b_free, commit;
  logic [ADDR_W-1:2] wr_idx;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;
  logic [31:0]       wr_off;
  reg_dec_t          wr_dec;
  logic [1:0]        wr_resp;
  logic              wr_counted;
  logic [31:0]       scratch_m, out_m32, tri_m32;

  // Read path signals
  logic              ar_fire;
  logic [31:0]       rd_off;
  reg_dec_t          rd_dec;
  logic [31:0]       rd_val;
  logic [1:0]        rd_resp;

  gpio_sync #(.GPIO_W(GPIO_W)) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw    (gpio_io_i),
    .synced (gpio_in_sync),
    .rise   (gpio_rise)
  );

  assign m_axi_lite_awready = !aw_held;
  assign m_axi_lite_wready  = !w_held;
  assign m_axi_lite_arready = !m_axi_lite_rvalid || m_axi_lite_rready;

  assign aw_fire = m_axi_lite_awvalid && m_axi_lite_awready;
  assign w_fire  = m_axi_lite_wvalid && m_axi_lite_wready;
  assign b_free  = !m_axi_lite_bvalid || m_axi_lite_bready;
  assign commit  = (aw_held || aw_fire) && (w_held || w_fire) && b_free;
  assign ar_fire = m_axi_lite_arvalid && m_axi_lite_arready;

  assign wr_idx  = aw_held ? aw_addr_q : m_axi_lite_awaddr[ADDR_W-1:2];
  assign wr_data = w_held ? w_data_q : m_axi_lite_wdata;
  assign wr_strb = w_held ? w_strb_q : m_axi_lite_wstrb;
  assign wr_off  = 32'({wr_idx, 2'b00});
  assign rd_off  = 32'({m_axi_lite_araddr[ADDR_W-1:2], 2'b00});

  // Write decode: response code, counted-write qualifier and merged values.
  always_comb begin
    wr_dec     = decode_offset(wr_off, EDGE_EN);
    wr_resp    = wr_dec.hit ? RESP_OKAY : RESP_SLVERR;
    wr_counted = 1'b0;
    if (commit && wr_dec.hit) begin
      case (wr_dec.sel)
        SEL_SCRATCH, SEL_GPIO_OUT, SEL_GPIO_TRI, SEL_EDGE: wr_counted = 1'b1;
        default:                                           wr_counted = 1'b0;
      endcase
    end
    scratch_m = apply_strb(scratch_q, wr_data, wr_strb);
    out_m32   = apply_strb(32'(gpio_o_q), wr_data, wr_strb);
    tri_m32   = apply_strb(32'(gpio_t_q), wr_data, wr_strb);
  end

  // AW/W holds fill when a handshake cannot commit at once, and empty on commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held   <= 1'b0;
      aw_addr_q <= '0;
      w_held    <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      if (commit) begin
        aw_held <= 1'b0;
      end else if (aw_fire) begin
        aw_held   <= 1'b1;
        aw_addr_q <= m_axi_lite_awaddr[ADDR_W-1:2];
      end
      if (commit) begin
        w_held <= 1'b0;
      end else if (w_fire) begin
        w_held   <= 1'b1;
        w_data_q <= m_axi_lite_wdata;
        w_strb_q <= m_axi_lite_wstrb;
      end
    end
  end

  // B channel: a commit loads a response; it drops once the master takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axi_lite_bvalid <= 1'b0;
      m_axi_lite_bresp  <= RESP_OKAY;
    end else if (commit) begin
      m_axi_lite_bvalid <= 1'b1;
      m_axi_lite_bresp  <= wr_resp;
    end else if (m_axi_lite_bready) begin
      m_axi_lite_bvalid <= 1'b0;
    end
  end

  // Register file updates, free-running cycle counter and write counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scratch_q  <= '0;
      gpio_o_q   <= '0;
      gpio_t_q   <= '1;
      cycles_q   <= '0;
      wr_count_q <= '0;
    end else begin
      cycles_q <= cycles_q + 32'd1;
      if (commit && wr_dec.hit) begin
        case (wr_dec.sel)
          SEL_SCRATCH:  scratch_q <= scratch_m;
          SEL_GPIO_OUT: gpio_o_q  <= out_m32[GPIO_W-1:0];
          SEL_GPIO_TRI: gpio_t_q  <= tri_m32[GPIO_W-1:0];
          default:      ;
        endcase
      end
      if (wr_counted) wr_count_q <= wr_count_q + 32'd1;
    end
  end

`ifdef AXIL_GPIO_EDGE_EN
  logic [GPIO_W-1:0] edge_clr;
  assign edge_clr = (commit && wr_dec.hit && (wr_dec.sel == SEL_EDGE) && wr_strb[0])
                    ? wr_data[GPIO_W-1:0] : '0;

  // Sticky edge flags: W1C, with a new edge winning over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_q <= '0;
    else        edge_q <= (edge_q & ~edge_clr) | gpio_rise;
  end
`else
  assign edge_q = '0;
`endif

  // Read mux samples current register values, so a same-cycle write is not seen.
  always_comb begin
    rd_dec  = decode_offset(rd_off, EDGE_EN);
    rd_val  = '0;
    rd_resp = RESP_SLVERR;
    if (rd_dec.hit) begin
      rd_resp = RESP_OKAY;
      case (rd_dec.sel)
        SEL_ID:       rd_val = ID_VALUE;
        SEL_SCRATCH:  rd_val = scratch_q;
        SEL_GPIO_OUT: rd_val = 32'(gpio_o_q);
        SEL_GPIO_TRI: rd_val = 32'(gpio_t_q);
        SEL_GPIO_IN:  rd_val = 32'(gpio_in_sync);
        SEL_CYCLES:   rd_val = cycles_q;
        SEL_WR_COUNT: rd_val = wr_count_q;
        SEL_EDGE:     rd_val = 32'(edge_q);
        default:      rd_val = '0;
      endcase
    end
  end

  // R channel: capture data on AR handshake, hold it until rready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axi_lite_rvalid <= 1'b0;
      m_axi_lite_rdata  <= '0;
      m_axi_lite_rresp  <= RESP_OKAY;
    end else if (ar_fire) begin
      m_axi_lite_rvalid <= 1'b1;
      m_axi_lite_rdata  <= rd_val;
      m_axi_lite_rresp  <= rd_resp;
    end else if (m_axi_lite_rready) begin
      m_axi_lite_rvalid <= 1'b0;
    end
  end

  assign gpio_io_o = gpio_o_q;
  assign gpio_io_t = gpio_t_q;

  logic unused_bits;
  assign unused_bits = ^{m_axi_lite_awprot, m_axi_lite_arprot, m_axi_lite_awaddr[1:0],
                         m_axi_lite_araddr[1:0], out_m32, tri_m32, gpio_rise};

endmodule

// File: tb/tb_axil_gpio_regs.sv
// Directed bench for axil_gpio_regs: each task drives one scenario and checks
// its own results inline against hand-computed values.
module tb_axil_gpio_regs;

  logic        clk;
  logic        rst_n;
  logic        awvalid, awready;
  logic [8:0]  awaddr;
  logic [2:0]  awprot;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [8:0]  araddr;
  logic [2:0]  arprot;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [1:0]  gpio_i, gpio_o, gpio_t;

  int check_cnt = 0;
  int pass_cnt  = 0;

  axil_gpio_regs dut (
    .m_axi_lite_aclk    (clk),
    .m_axi_lite_aresetn (rst_n),
    .m_axi_lite_awvalid (awvalid),
    .m_axi_lite_awready (awready),
    .m_axi_lite_awaddr  (awaddr),
    .m_axi_lite_awprot  (awprot),
    .m_axi_lite_wvalid  (wvalid),
    .m_axi_lite_wready  (wready),
    .m_axi_lite_wdata   (wdata),
    .m_axi_lite_wstrb   (wstrb),
    .m_axi_lite_bvalid  (bvalid),
    .m_axi_lite_bready  (bready),
    .m_axi_lite_bresp   (bresp),
    .m_axi_lite_arvalid (arvalid),
    .m_axi_lite_arready (arready),
    .m_axi_lite_araddr  (araddr),
    .m_axi_lite_arprot  (arprot),
    .m_axi_lite_rvalid  (rvalid),
    .m_axi_lite_rready  (rready),
    .m_axi_lite_rdata   (rdata),
    .m_axi_lite_rresp   (rresp),
    .gpio_io_i          (gpio_i),
    .gpio_io_o          (gpio_o),
    .gpio_io_t          (gpio_t)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Driver: full write, AW and W together, returns bresp.
  task automatic axi_write(input logic [8:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] resp);
    bit aw_pend, w_pend, aw_go, w_go;
    int n;
    aw_pend = 1; w_pend = 1; n = 0;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1; wvalid = 1; bready = 1;
    while ((aw_pend || w_pend) && n < 50) begin
      aw_go = awvalid && awready;
      w_go  = wvalid && wready;
      cyc(); n++;
      if (aw_go) begin awvalid = 0; aw_pend = 0; end
      if (w_go)  begin wvalid = 0;  w_pend = 0;  end
    end
    while (!bvalid && n < 50) begin cyc(); n++; end
    if (n >= 50) begin
      check_cnt++;
      $display("FAIL write_timeout addr=%h got no bvalid, required bvalid within 50 cycles", a);
      awvalid = 0; wvalid = 0; bready = 0; resp = 2'bxx;
    end else begin
      resp = bresp;
      cyc();
      bready = 0;
    end
  endtask

  // Driver: full read, returns data, resp and cycles from AR handshake to rvalid.
  task automatic axi_read(input logic [8:0] a, output logic [31:0] d,
                          output logic [1:0] resp, output int lat);
    bit go;
    int n;
    go = 0; n = 0;
    araddr = a; arvalid = 1; rready = 0;
    while (!go && n < 50) begin go = arready; cyc(); n++; end
    arvalid = 0;
    lat = 1;
    while (!rvalid && n < 50) begin cyc(); n++; lat++; end
    if (n >= 50) begin
      check_cnt++;
      $display("FAIL read_timeout addr=%h got no rvalid, required rvalid within 50 cycles", a);
      d = 'x; resp = 2'bxx;
    end else begin
      d = rdata; resp = rresp;
      rready = 1;
      cyc();
      rready = 0;
    end
  endtask

  task automatic test_reset();
    logic [11:0] got;
    got = {awready, wready, arready, bvalid, rvalid, bresp, rresp, gpio_o, gpio_t[1]};
    check_cnt++;
    if (got !== 12'b1110_0000_0001) $display("FAIL reset_ctrl got=%b required=111000000001", got);
    else pass_cnt++;
    check_cnt++;
    if (rdata !== 32'h0) $display("FAIL reset_rdata got=%h required=00000000", rdata);
    else pass_cnt++;
    check_cnt++;
    if (gpio_t !== 2'b11) $display("FAIL reset_gpio_t got=%b required=11", gpio_t);
    else pass_cnt++;
  endtask

  task automatic test_id_read();
    logic [31:0] d; logic [1:0] r; int lat;
    axi_read(9'h000, d, r, lat);
    check_cnt++;
    if (d !== 32'hBE4C_0001) $display("FAIL id_rdata got=%h required=BE4C0001", d);
    else pass_cnt++;
    check_cnt++;
    if (r !== 2'b00) $display("FAIL id_rresp got=%b required=00", r);
    else pass_cnt++;
    check_cnt++;
    if (lat !== 1) $display("FAIL id_latency got=%0d required=1", lat);
    else pass_cnt++;
  endtask

  task automatic test_split_write();
    logic [31:0] d; logic [1:0] r; int lat;
    awaddr = 9'h004; awvalid = 1; bready = 0;
    cyc();
    awvalid = 0;
    check_cnt++;
    if (awready !== 1'b0 || bvalid !== 1'b0)
      $display("FAIL split_aw_held got awready=%b bvalid=%b required awready=0 bvalid=0", awready, bvalid);
    else pass_cnt++;
    cyc(); cyc();
    wdata = 32'hDEAD_BEEF; wstrb = 4'b0101; wvalid = 1;
    cyc();
    wvalid = 0;
    check_cnt++;
    if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b1)
      $display("FAIL split_bvalid got bvalid=%b bresp=%b awready=%b required 1 00 1", bvalid, bresp, awready);
    else pass_cnt++;
    bready = 1;
    cyc();
    bready = 0;
    check_cnt++;
    if (bvalid !== 1'b0) $display("FAIL split_bdrop got=%b required=0", bvalid);
    else pass_cnt++;
    axi_read(9'h004, d, r, lat);
    check_cnt++;
    if (d !== 32'h00AD_00EF) $display("FAIL split_scratch got=%h required=00AD00EF", d);
    else pass_cnt++;
    axi_read(9'h018, d, r, lat);
    check_cnt++;
    if (d !== 32'd1) $display("FAIL split_wr_count got=%0d required=1", d);
    else pass_cnt++;
  endtask

  task automatic test_b_backpressure();
    logic [31:0] d; logic [1:0] r; int lat;
    bready = 0;
    awaddr = 9'h008; wdata = 32'h3; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    cyc();
    awvalid = 0; wvalid = 0;
    check_cnt++;
    if (bvalid !== 1'b1 || gpio_o !== 2'b11)
      $display("FAIL bp_first got bvalid=%b gpio_o=%b required 1 11", bvalid, gpio_o);
    else pass_cnt++;
    awaddr = 9'h004; wdata = 32'h1234_5678; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    cyc();
    awvalid = 0; wvalid = 0;
    for (int i = 0; i < 3; i++) begin
      check_cnt++;
      if (awready !== 1'b0 || wready !== 1'b0 || bvalid !== 1'b1 || bresp !== 2'b00)
        $display("FAIL bp_hold%0d got awready=%b wready=%b bvalid=%b bresp=%b required 0 0 1 00",
                 i, awready, wready, bvalid, bresp);
      else pass_cnt++;
      cyc();
    end
    bready = 1;
    cyc();
    check_cnt++;
    if (bvalid !== 1'b1 || awready !== 1'b1)
      $display("FAIL bp_second_b got bvalid=%b awready=%b required 1 1", bvalid, awready);
    else pass_cnt++;
    cyc();
    bready = 0;
    check_cnt++;
    if (bvalid !== 1'b0) $display("FAIL bp_drain got bvalid=%b required 0", bvalid);
    else pass_cnt++;
    axi_read(9'h018, d, r, lat);
    check_cnt++;
    if (d !== 32'd3) $display("FAIL bp_wr_count got=%0d required=3", d);
    else pass_cnt++;
  endtask

  task automatic test_unmapped();
    logic [31:0] d; logic [1:0] r; int lat;
    logic [1:0] edge_resp;
`ifdef AXIL_GPIO_EDGE_EN
    edge_resp = 2'b00;
`else
    edge_resp = 2'b10;
`endif
    axi_write(9'h100, 32'hFFFF_FFFF, 4'hF, r);
    check_cnt++;
    if (r !== 2'b10) $display("FAIL unmapped_bresp got=%b required=10", r);
    else pass_cnt++;
    axi_read(9'h100, d, r, lat);
    check_cnt++;
    if (d !== 32'h0 || r !== 2'b10) $display("FAIL unmapped_read got=%h/%b required=00000000/10", d, r);
    else pass_cnt++;
    axi_write(9'h000, 32'h1111_1111, 4'hF, r);
    check_cnt++;
    if (r !== 2'b00) $display("FAIL ro_write_bresp got=%b required=00", r);
    else pass_cnt++;
    axi_read(9'h000, d, r, lat);
    check_cnt++;
    if (d !== 32'hBE4C_0001) $display("FAIL ro_write_id got=%h required=BE4C0001", d);
    else pass_cnt++;
    axi_read(9'h018, d, r, lat);
    check_cnt++;
    if (d !== 32'd3) $display("FAIL unmapped_wr_count got=%0d required=3", d);
    else pass_cnt++;
    axi_read(9'h01C, d, r, lat);
    check_cnt++;
    if (r !== edge_resp) $display("FAIL edge_map_rresp got=%b required=%b", r, edge_resp);
    else pass_cnt++;
  endtask

  task automatic test_same_cycle();
    logic [31:0] d; logic [1:0] r; int lat;
    araddr = 9'h004; arvalid = 1; rready = 0;
    awaddr = 9'h004; wdata = 32'hCAFE_F00D; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
    cyc();
    arvalid = 0; awvalid = 0; wvalid = 0;
    check_cnt++;
    if (rvalid !== 1'b1 || rdata !== 32'h1234_5678 || bvalid !== 1'b1)
      $display("FAIL same_cycle_read got rvalid=%b rdata=%h bvalid=%b required 1 12345678 1",
               rvalid, rdata, bvalid);
    else pass_cnt++;
    rready = 1;
    cyc();
    rready = 0; bready = 0;
    axi_read(9'h004, d, r, lat);
    check_cnt++;
    if (d !== 32'hCAFE_F00D) $display("FAIL same_cycle_after got=%h required=CAFEF00D", d);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] c1, c2; logic [1:0] r; int lat;
    axi_read(9'h014, c1, r, lat);
    axi_read(9'h014, c2, r, lat);
    check_cnt++;
    if (c2 - c1 !== 32'd2) $display("FAIL cycles_delta got=%0d required=2", c2 - c1);
    else pass_cnt++;
  endtask

  task automatic test_gpio();
    logic [31:0] d; logic [1:0] r; int lat;
    axi_write(9'h00C, 32'h0, 4'h1, r);
    check_cnt++;
    if (gpio_t !== 2'b00 || r !== 2'b00) $display("FAIL gpio_tri got=%b/%b required=00/00", gpio_t, r);
    else pass_cnt++;
    gpio_i = 2'b01;
    axi_read(9'h010, d, r, lat);
    check_cnt++;
    if (d !== 32'h0) $display("FAIL gpio_in_early got=%h required=00000000", d);
    else pass_cnt++;
    axi_read(9'h010, d, r, lat);
    check_cnt++;
    if (d !== 32'h1) $display("FAIL gpio_in_sync got=%h required=00000001", d);
    else pass_cnt++;
`ifdef AXIL_GPIO_EDGE_EN
    axi_read(9'h01C, d, r, lat);
    check_cnt++;
    if (d !== 32'h1) $display("FAIL edge_set got=%h required=00000001", d);
    else pass_cnt++;
    axi_write(9'h01C, 32'h1, 4'h1, r);
    axi_read(9'h01C, d, r, lat);
    check_cnt++;
    if (d !== 32'h0) $display("FAIL edge_clear got=%h required=00000000", d);
    else pass_cnt++;
`endif
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [1:0] r; int lat;
    axi_write(9'h004, 32'h55AA_55AA, 4'hF, r);
    araddr = 9'h004; arvalid = 1; rready = 0;
    cyc();
    arvalid = 0;
    check_cnt++;
    if (rvalid !== 1'b1) $display("FAIL rst_mid_pending got rvalid=%b required=1", rvalid);
    else pass_cnt++;
    #2 rst_n = 0;
    #1;
    check_cnt++;
    if (rvalid !== 1'b0 || gpio_t !== 2'b11 || gpio_o !== 2'b00)
      $display("FAIL rst_mid_state got rvalid=%b gpio_t=%b gpio_o=%b required 0 11 00", rvalid, gpio_t, gpio_o);
    else pass_cnt++;
    cyc();
    rst_n = 1;
    cyc();
    axi_read(9'h004, d, r, lat);
    check_cnt++;
    if (d !== 32'h0) $display("FAIL rst_mid_scratch got=%h required=00000000", d);
    else pass_cnt++;
  endtask

  initial begin
    rst_n = 0;
    awvalid = 0; awaddr = '0; awprot = '0;
    wvalid = 0; wdata = '0; wstrb = '0; bready = 0;
    arvalid = 0; araddr = '0; arprot = '0; rready = 0;
    gpio_i = '0;
    repeat (3) cyc();
    test_reset();
    rst_n = 1;
    cyc();
    test_id_read();
    test_split_write();
    test_b_backpressure();
    test_unmapped();
    test_same_cycle();
    test_back_to_back();
    test_gpio();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
